// File: rtl/tt_mux_seq_pkg.sv
// rtl/tt_mux_seq_pkg.sv - shared state encoding and timing defaults for the mux select sequencer
package tt_mux_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DISABLE,
        ST_SELRST,
        ST_INC_HI,
        ST_INC_LO,
        ST_DONE
    } state_t;

    localparam int PULSE_CYC_DEF  = 2;
    localparam int SETTLE_CYC_DEF = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tt_mux_pulse_timer.sv
// rtl/tt_mux_pulse_timer.sv - loadable down-counter with terminal-count strobe
module tt_mux_pulse_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/tt_mux_select_seq.sv
// rtl/tt_mux_select_seq.sv - mux select/enable pulse sequencer; optional TT_MUX_SEQ_INCREMENTAL_EN skips select reset
module tt_mux_select_seq
    import tt_mux_seq_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int PULSE_CYC  = PULSE_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int               CNT_W = $clog2(max2(PULSE_CYC, SETTLE_CYC)) + 1;
    localparam logic [CNT_W-1:0] P_LD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] S_LD  = CNT_W'(SETTLE_CYC - 1);

    state_t            state;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] remaining;
    logic              tc;
    logic              load;
    logic [CNT_W-1:0]  load_val;

    // Every phase ends on terminal count; only DISABLE (entered from IDLE) uses the settle length.
    always_comb begin
        load     = tc || (state == ST_IDLE);
        load_val = (state == ST_IDLE) ? S_LD : P_LD;
    end

    tt_mux_pulse_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (P_LD)
    ) u_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

`ifdef TT_MUX_SEQ_INCREMENTAL_EN
    logic [ADDR_W-1:0] delta;
    assign delta = tgt - cur_addr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_INIT;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            cur_addr       <= '0;
            tgt            <= '0;
            remaining      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (tc) begin
                        state          <= ST_IDLE;
                        ctrl_sel_rst_n <= 1'b1;
                        req_ready      <= 1'b1;
                        busy           <= 1'b0;
                        cur_addr       <= '0;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        state     <= ST_DISABLE;
                        tgt       <= req_addr;
                        ctrl_ena  <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_DISABLE: begin
                    if (tc) begin
`ifdef TT_MUX_SEQ_INCREMENTAL_EN
                        if (tgt >= cur_addr) begin
                            remaining <= delta;
                            if (delta == '0) begin
                                state    <= ST_DONE;
                                done     <= 1'b1;
                                ctrl_ena <= 1'b1;
                            end else begin
                                state        <= ST_INC_HI;
                                ctrl_sel_inc <= 1'b1;
                            end
                        end else begin
                            state          <= ST_SELRST;
                            ctrl_sel_rst_n <= 1'b0;
                        end
`else
                        state          <= ST_SELRST;
                        ctrl_sel_rst_n <= 1'b0;
`endif
                    end
                end
                ST_SELRST: begin
                    if (tc) begin
                        ctrl_sel_rst_n <= 1'b1;
                        cur_addr       <= '0;
                        remaining      <= tgt;
                        if (tgt == '0) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            ctrl_ena <= 1'b1;
                        end else begin
                            state        <= ST_INC_HI;
                            ctrl_sel_inc <= 1'b1;
                        end
                    end
                end
                ST_INC_HI: begin
                    if (tc) begin
                        state        <= ST_INC_LO;
                        ctrl_sel_inc <= 1'b0;
                    end
                end
                ST_INC_LO: begin
                    if (tc) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        // Checking for 1 before the decrement keeps an all-ones target from wrapping.
                        if (remaining == ADDR_W'(1)) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            ctrl_ena <= 1'b1;
                        end else begin
                            state        <= ST_INC_HI;
                            ctrl_sel_inc <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: doc/tt_mux_select_seq.md
# tt_mux_select_seq

Sequencer that drives the three-wire mux control interface (`ctrl_sel_rst_n`, `ctrl_sel_inc`, `ctrl_ena`) so that a requested project address is selected and enabled. The requester supplies a target address through a valid/ready handshake. The block then generates the disable, select-reset and increment pulse train with programmable pulse and settle timing. It sits between the management/test controller and the mux control pins, and replaces hand-written pin wiggling in benches and firmware.

## Interface
- `ADDR_W`, 10, width of the project address and select counter.
- `PULSE_CYC`, 2, clock cycles per pulse phase (high or low); must be ≥1.
- `SETTLE_CYC`, 4, cycles `ctrl_ena` is held low before reselecting; must be ≥1.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  block idle, will accept a request.
- `req_addr`  in  ADDR_W  target project address.
- `ctrl_sel_rst_n`  out  1  mux select-counter reset, active low.
- `ctrl_sel_inc`  out  1  mux select-counter increment pulse.
- `ctrl_ena`  out  1  mux enable for the selected project.
- `busy`  out  1  sequence in progress (the inverse of `req_ready`).
- `done`  out  1  one-cycle pulse when the target is enabled.
- `cur_addr`  out  ADDR_W  address the mux counter currently holds.

## Operation
- States: INIT, IDLE, DISABLE, SELRST, INC_HI, INC_LO, DONE.
- Reset values:
  - `ctrl_sel_rst_n`=0, `ctrl_sel_inc`=0, `ctrl_ena`=0.
  - `req_ready`=0, `busy`=1, `done`=0, `cur_addr`=0.
  - State is INIT.
- INIT: holds `ctrl_sel_rst_n`=0 for PULSE_CYC cycles, then moves to IDLE with `cur_addr`=0.
- IDLE: `req_ready`=1. `ctrl_ena` keeps its last value (0 after INIT, 1 after any DONE). A handshake occurs when `req_valid`&&`req_ready` at a rising edge. At that edge the block latches `req_addr` into `tgt` and goes to DISABLE.
- DISABLE: `ctrl_ena`=0 for SETTLE_CYC cycles, then goes to SELRST, or skips it (see Configuration).
- SELRST: `ctrl_sel_rst_n`=0 for PULSE_CYC cycles. Then `cur_addr`←0 and `remaining`←`tgt`.
- Increment loop:
  - If `remaining`==0, go to DONE.
  - Otherwise INC_HI (`ctrl_sel_inc`=1, PULSE_CYC cycles) then INC_LO (`ctrl_sel_inc`=0, PULSE_CYC cycles).
  - At the end of each INC_LO, `cur_addr` increments and `remaining` decrements.
- DONE: for one cycle, `done`=1, `ctrl_ena`=1, `req_ready`=0. The block then returns to IDLE.
- Width rules:
  - `remaining` and `cur_addr` are ADDR_W bits.
  - `tgt`=2^ADDR_W−1 produces exactly 2^ADDR_W−1 pulses, with no wrap.
  - `tgt`=0 produces zero pulses.
- While busy, `req_valid` is ignored and `req_addr` is not sampled.
- Asserting `reset` mid-sequence forces all outputs to their reset values immediately and re-runs INIT.
- `ctrl_sel_inc` and `ctrl_sel_rst_n`=0 are never asserted in the same cycle.
- `ctrl_ena` is never 1 while either of them is active.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Handshake at edge E. In the first cycle after E, `busy`=1 and `ctrl_ena`=0.
- Busy duration (full path) = SETTLE_CYC + PULSE_CYC + 2·PULSE_CYC·N + 1 cycles, where N=`tgt`. With defaults and N=3 this is 19 cycles.
- Incremental path (macro enabled) = SETTLE_CYC + 2·PULSE_CYC·(tgt−cur_addr) + 1 cycles.
- `done` and the first `ctrl_ena`=1 occur in the same cycle. `req_ready`=1 in the following cycle.
- Back-to-back requests: the minimum gap between handshakes is the busy duration plus 1.

## Configuration
- `TT_MUX_SEQ_INCREMENTAL_EN` defined: if `tgt`≥`cur_addr` after reset/INIT, DISABLE goes directly to the increment loop with `remaining`=`tgt`−`cur_addr`, skipping SELRST. If `tgt`<`cur_addr`, the full SELRST path is used. If `tgt`==`cur_addr`, the sequence is DISABLE then DONE.
- Not defined: every request uses the full SELRST path.

## Structure
- Package `tt_mux_seq_pkg`: the state enum and the default values of PULSE_CYC/SETTLE_CYC.
- Sub-module `tt_mux_pulse_timer`: a loadable down-counter producing a terminal-count strobe. It is shared by the INIT, DISABLE, SELRST and INC phases.

## Test plan
- Reset deassert, defaults: `ctrl_sel_rst_n` low for 2 cycles, then `req_ready`=1, `cur_addr`=0, `ctrl_ena`=0.
- Request addr 3, macro off: `ctrl_ena` low 4 cycles, `sel_rst_n` low 2 cycles, 3 inc pulses each 2 high/2 low, `done` on busy cycle 19, `cur_addr`=3, `ctrl_ena`=1.
- Then request addr 5, macro on: no `sel_rst_n` pulse, 2 inc pulses, busy 13 cycles, `cur_addr`=5. Then request addr 1: full reset path with 1 pulse.
- Request addr 0: no inc pulses, busy 7 cycles (SETTLE+PULSE+1), `done`, `ctrl_ena`=1. With the macro on and `cur_addr`=0: busy 5 cycles.
- `req_valid` with addr 9 asserted while busy: ignored, the current target is unchanged. Assert `reset` during INC_HI: outputs go to reset values immediately, INIT re-runs, `cur_addr`=0.
- ADDR_W=4, PULSE_CYC=1, request addr 15: exactly 15 pulses, `cur_addr`=15, no wrap.
